// File: rtl/maze_player_ctrl.sv
// Debounced button-driven player walker over a wall-lookup port; flags arrival at the goal cell.
// Latency: request in IDLE at t -> player/move_pulse update at end of t+2; no backpressure, busy-time requests dropped.
module maze_player_ctrl #(
   parameter int COORD_W         = 3,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               maze_ready,
   input  logic [COORD_W-1:0] maze_width,
   input  logic [COORD_W-1:0] maze_height,
   input  logic [3:0]         btn,
   output logic [COORD_W-1:0] cell_x,
   output logic [COORD_W-1:0] cell_y,
   input  logic [3:0]         cell_open,
   output logic [COORD_W-1:0] player_x,
   output logic [COORD_W-1:0] player_y,
   output logic [CNT_W-1:0]   move_count,
   output logic               move_pulse,
   output logic               at_goal
);

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

   // direction index doubles as the cell_open bit index: 0=up/N 1=right/E 2=down/S 3=left/W
   typedef enum logic [2:0] {
      WAIT_MAZE,
      IDLE,
      FETCH,
      CHECK,
      MOVE,
      GOAL
   } state_t;

   state_t             state, state_nxt;
   logic [3:0]         deb, deb_prev, rise;
   logic [DW-1:0]      db_cnt [4];
   logic [1:0]         dir, dir_nxt, req_dir;
   logic               req_any;
   logic [3:0]         open_q, open_nxt;
   logic [COORD_W-1:0] px, py, px_nxt, py_nxt;
   logic [CNT_W-1:0]   count, count_nxt;
   logic               pulse_nxt;
   logic               legal, goal_cell;

   always_ff @(posedge clk) begin
      if (reset) begin
         deb      <= '0;
         deb_prev <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         deb_prev <= deb;
         for (int i = 0; i < 4; i++) begin
            if (btn[i] != deb[i]) begin
               if (db_cnt[i] == DB_MAX) begin
                  deb[i]    <= btn[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   assign rise = deb & ~deb_prev;

   always_comb begin
      req_any = |rise;
      req_dir = 2'd0;
      if (rise[0])      req_dir = 2'd0;
      else if (rise[1]) req_dir = 2'd1;
      else if (rise[2]) req_dir = 2'd2;
      else if (rise[3]) req_dir = 2'd3;
   end

   assign goal_cell = (px == maze_width - 1'b1) && (py == maze_height - 1'b1);

   always_comb begin
      legal = 1'b0;
      case (dir)
         2'd0: legal = open_q[0] && (py != '0);
         2'd1: legal = open_q[1] && (({1'b0, px} + 1'b1) < {1'b0, maze_width});
         2'd2: legal = open_q[2] && (({1'b0, py} + 1'b1) < {1'b0, maze_height});
         default: legal = open_q[3] && (px != '0);
      endcase
   end

   always_comb begin
      state_nxt = state;
      px_nxt    = px;
      py_nxt    = py;
      count_nxt = count;
      pulse_nxt = 1'b0;
      dir_nxt   = dir;
      open_nxt  = open_q;
      case (state)
         WAIT_MAZE: begin
            px_nxt    = '0;
            py_nxt    = '0;
            count_nxt = '0;
            if (maze_ready) state_nxt = IDLE;
         end
         IDLE: begin
            // only a 1x1 maze can sit on the goal here
            if (goal_cell) begin
               state_nxt = GOAL;
            end else if (req_any) begin
               dir_nxt   = req_dir;
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            open_nxt  = cell_open;
            state_nxt = CHECK;
         end
         CHECK: begin
            if (legal) begin
               case (dir)
                  2'd0: py_nxt = py - 1'b1;
                  2'd1: px_nxt = px + 1'b1;
                  2'd2: py_nxt = py + 1'b1;
                  default: px_nxt = px - 1'b1;
               endcase
               pulse_nxt = 1'b1;
               if (count != '1) count_nxt = count + 1'b1;
               state_nxt = MOVE;
            end else begin
               state_nxt = IDLE;
            end
         end
         MOVE: state_nxt = goal_cell ? GOAL : IDLE;
         GOAL: state_nxt = GOAL;
         default: state_nxt = WAIT_MAZE;
      endcase
      if (!maze_ready) begin
         state_nxt = WAIT_MAZE;
         px_nxt    = '0;
         py_nxt    = '0;
         count_nxt = '0;
         pulse_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= WAIT_MAZE;
         px         <= '0;
         py         <= '0;
         count      <= '0;
         move_pulse <= 1'b0;
         dir        <= 2'd0;
         open_q     <= '0;
      end else begin
         state      <= state_nxt;
         px         <= px_nxt;
         py         <= py_nxt;
         count      <= count_nxt;
         move_pulse <= pulse_nxt;
         dir        <= dir_nxt;
         open_q     <= open_nxt;
      end
   end

   assign cell_x     = (state == WAIT_MAZE) ? '0 : px;
   assign cell_y     = (state == WAIT_MAZE) ? '0 : py;
   assign player_x   = px;
   assign player_y   = py;
   assign move_count = count;
   assign at_goal    = (state == GOAL);

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Directed bench for maze_player_ctrl with a 4x4 wall memory answering one cycle late.
module tb_maze_player_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        maze_ready;
   logic [2:0]  maze_width, maze_height;
   logic [3:0]  btn;
   logic [2:0]  cell_x, cell_y;
   logic [3:0]  cell_open;
   logic [2:0]  player_x, player_y;
   logic [15:0] move_count;
   logic        move_pulse;
   logic        at_goal;

   logic [3:0]  mem [16];
   int          total = 0;
   int          bad = 0;
   int          pulses = 0;

   always #5 clk = ~clk;

   maze_player_ctrl #(.COORD_W(3), .DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .maze_ready(maze_ready),
      .maze_width(maze_width), .maze_height(maze_height), .btn(btn),
      .cell_x(cell_x), .cell_y(cell_y), .cell_open(cell_open),
      .player_x(player_x), .player_y(player_y), .move_count(move_count),
      .move_pulse(move_pulse), .at_goal(at_goal)
   );

   always @(posedge clk) cell_open <= mem[{cell_y[1:0], cell_x[1:0]}];
   always @(negedge clk) if (move_pulse) pulses++;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] b);
      btn = b;
      tick(6);
      btn = 4'b0000;
      tick(12);
   endtask

   task automatic chk_pos(input string tag, input int x, input int y, input int c);
      chk({tag, "_x"}, player_x, x);
      chk({tag, "_y"}, player_y, y);
      chk({tag, "_cnt"}, move_count, c);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 4'hF;
      reset = 1'b1; maze_ready = 1'b0; btn = 4'b0000;
      maze_width = 3'd4; maze_height = 3'd4;
      tick(3);
      chk_pos("rst", 0, 0, 0);
      chk("rst_pulse", move_pulse, 0);
      chk("rst_goal", at_goal, 0);
      chk("rst_cellx", cell_x, 0);
      reset = 1'b0; maze_ready = 1'b1;
      tick(2);

      // 1: right move with exact latency
      btn = 4'b0010;
      tick(6);
      btn = 4'b0000;
      chk("t1_early_x", player_x, 0);
      tick(1);
      chk("t1_pulse_hi", move_pulse, 1);
      chk("t1_x_now", player_x, 1);
      tick(1);
      chk("t1_pulse_lo", move_pulse, 0);
      tick(12);
      chk_pos("t1", 1, 0, 1);
      chk("t1_cellx", cell_x, 1);
      chk("t1_pulses", pulses, 1);

      maze_ready = 1'b0;
      tick(2);
      chk_pos("restart", 0, 0, 0);
      maze_ready = 1'b1;
      tick(2);

      // 2: wall to the east
      mem[0] = 4'b1101;
      press(4'b0010);
      chk_pos("t2_wall", 0, 0, 0);
      mem[0] = 4'hF;

      // 3: bounds block up and left
      press(4'b0001);
      chk_pos("t3_up", 0, 0, 0);
      press(4'b1000);
      chk_pos("t3_left", 0, 0, 0);

      // 4: short glitch, then up+right together
      btn = 4'b0100;
      tick(2);
      btn = 4'b0000;
      tick(12);
      chk_pos("t4_glitch", 0, 0, 0);
      press(4'b0011);
      chk_pos("t4_prio", 0, 0, 0);
      chk("t4_pulses", pulses, 1);

      // 5: walk to the goal, with an east-edge bound check on the way
      press(4'b0010); press(4'b0010); press(4'b0010);
      chk_pos("t5_r3", 3, 0, 3);
      press(4'b0010);
      chk_pos("t5_edge", 3, 0, 3);
      press(4'b0100); press(4'b0100);
      chk("t5_not_goal", at_goal, 0);
      press(4'b0100);
      chk_pos("t5_goal", 3, 3, 6);
      chk("t5_at_goal", at_goal, 1);
      chk("t5_celly", cell_y, 3);
      chk("t5_pulses", pulses, 7);
      press(4'b1000);
      chk_pos("t5_locked", 3, 3, 6);
      chk("t5_still_goal", at_goal, 1);

      // 6a: maze_ready drops during CHECK
      maze_ready = 1'b0;
      tick(1);
      chk("t6_goal_clr", at_goal, 0);
      chk_pos("t6_wait", 0, 0, 0);
      maze_ready = 1'b1;
      tick(2);
      press(4'b0010);
      chk_pos("t6_pre", 1, 0, 1);
      btn = 4'b0100;
      tick(6);
      maze_ready = 1'b0;
      tick(1);
      chk_pos("t6_drop", 0, 0, 0);
      chk("t6_drop_pulse", move_pulse, 0);
      chk("t6_drop_cellx", cell_x, 0);
      btn = 4'b0000;
      maze_ready = 1'b1;
      tick(14);

      // 6b: reset during FETCH
      press(4'b0010);
      chk_pos("t6_pre2", 1, 0, 1);
      btn = 4'b0100;
      tick(5);
      reset = 1'b1;
      tick(1);
      chk_pos("t6_rst", 0, 0, 0);
      chk("t6_rst_pulse", move_pulse, 0);
      chk("t6_rst_cellx", cell_x, 0);
      chk("t6_rst_goal", at_goal, 0);
      btn = 4'b0000;

      // 1x1 maze starts on the goal
      maze_width = 3'd1; maze_height = 3'd1;
      tick(1);
      reset = 1'b0;
      tick(3);
      chk("one_goal", at_goal, 1);
      chk_pos("one", 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
